// File: rtl/rssb_pkg.sv
// rssb_pkg: shared types and constants for the RSSB core and its loader.
//   loader_state_t : program loader FSM states
//   RSSB_WIDTH     : native data/address width of the core
package rssb_pkg;

  localparam int RSSB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } loader_state_t;

endpackage

// File: rtl/inc.sv
// inc: RSSB core incrementer (modular, a + 1).
// Ports:
//   a : operand
//   y : a + 1, wrapping at 2**WIDTH
module inc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = a + WIDTH'(1);

endmodule

// File: rtl/register.sv
// register: RSSB core general-purpose register with load enable.
// Ports:
//   clk, rst : clock, synchronous active-high reset (q <= RESET_VALUE)
//   write    : load d into q at the next clock edge
//   d / q    : data in / registered data out
module register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (write) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rssb_loader.sv
// rssb_loader: program loader for the RSSB core. Accepts a word stream over a
// valid/ready handshake and writes it into mem_data at sequential addresses
// starting at BASE_ADDR, holding the core in reset until the load completes.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : pulse that begins a load session (ignored while loading)
//   in_valid     : source presents a word on in_data
//   in_data      : program/data word
//   in_last      : final beat of the session
//   in_ready     : loader accepts a beat this cycle (high only in LOAD)
//   mem_write    : single-cycle write strobe to mem_data, one cycle after accept
//   mem_address  : write address
//   mem_wdata    : write data
//   cpu_hold     : drives the core's reset (1 = core held)
//   done         : load completed successfully
//   error        : overflow or checksum failure
//   count        : words written this session (held in DONE/ERROR)
//
// Optional feature, macro RSSB_LOADER_CHECKSUM_EN: the in_last beat carries a
// WIDTH-bit modular sum of all written words; it is compared, not written.
module rssb_loader
  import rssb_pkg::*;
#(
  parameter int WIDTH     = RSSB_WIDTH,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [WIDTH:0]   count
);

  localparam logic [WIDTH-1:0] BASE  = WIDTH'(BASE_ADDR);
  // Number of words that fit between BASE_ADDR and the end of memory.
  localparam logic [WIDTH:0]   LIMIT = (WIDTH + 1)'(DEPTH - BASE_ADDR);

  loader_state_t    state;
  logic [WIDTH-1:0] ptr;
  logic [WIDTH-1:0] ptr_inc;
  logic [WIDTH-1:0] ptr_d;
  logic             ptr_we;
  logic             accept;
  logic             full;
  logic             is_chk;
  logic             write_beat;
  logic             overflow;
  logic             start_load;

  assign in_ready   = (state == LOAD);
  assign accept     = in_ready && in_valid;
  assign full       = (count == LIMIT);
  assign start_load = start && (state != LOAD);

`ifdef RSSB_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] sum;
  assign is_chk = in_last;
`else
  assign is_chk = 1'b0;
`endif

  assign write_beat = accept && !is_chk && !full;
  assign overflow   = accept && !is_chk && full;

  // Address pointer: reloaded on a new session, advanced per written word.
  // It stops on the last legal address instead of wrapping past the end.
  assign ptr_d  = start_load ? BASE : ptr_inc;
  assign ptr_we = start_load || (write_beat && ((count + 1'b1) != LIMIT));

  inc #(
    .WIDTH (WIDTH)
  ) u_ptr_inc (
    .a (ptr),
    .y (ptr_inc)
  );

  register #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (BASE)
  ) u_ptr_reg (
    .clk   (clk),
    .rst   (rst),
    .write (ptr_we),
    .d     (ptr_d),
    .q     (ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cpu_hold    <= 1'b1;
      mem_write   <= 1'b0;
      mem_address <= BASE;
      mem_wdata   <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      count       <= '0;
`ifdef RSSB_LOADER_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      mem_write <= write_beat;
      if (write_beat) begin
        mem_address <= ptr;
        mem_wdata   <= in_data;
        count       <= count + 1'b1;
`ifdef RSSB_LOADER_CHECKSUM_EN
        sum         <= sum + in_data;
`endif
      end

      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state    <= LOAD;
            count    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
`ifdef RSSB_LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
          end
        end
        LOAD: begin
          if (overflow) begin
            state <= ERROR;
            error <= 1'b1;
          end else if (accept && in_last) begin
`ifdef RSSB_LOADER_CHECKSUM_EN
            if (in_data == sum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
`else
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
